// File: rtl/rggen_rtl_pkg.sv
// Shared register-bus definitions for the rggen host interfaces.
// Status codes returned by registers and an error classifier.
package rggen_rtl_pkg;

   typedef enum logic [1:0] {
      OKAY         = 2'd0,
      EXOKAY       = 2'd1,
      SLAVE_ERROR  = 2'd2,
      DECODE_ERROR = 2'd3
   } rggen_status;

   function automatic logic is_error(input rggen_status i_s);
      return (i_s == SLAVE_ERROR) || (i_s == DECODE_ERROR);
   endfunction

endpackage

// File: rtl/rggen_host_if_apb_watchdog.sv
// BUSY-phase watchdog: counts cycles spent in BUSY and flags the last one.
// Only instantiated when RGGEN_HOST_IF_APB_WATCHDOG_EN is defined.
module rggen_host_if_watchdog #(
   parameter int TIMEOUT_CYCLES = 256
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_start,
   input  logic i_busy,
   output logic o_timeout
);

   localparam int CW =
      (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES - 1);

   logic [CW-1:0] r_count;

   // Clear on entry to BUSY, count up while busy, hold at the limit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_count <= '0;
      end else if (i_start || !i_busy) begin
         r_count <= '0;
      end else if (r_count != LIMIT) begin
         r_count <= r_count + 1'b1;
      end
   end

   assign o_timeout = i_busy && (r_count == LIMIT);

endmodule

// File: rtl/rggen_host_if_apb.sv
// APB3/APB4 slave front end driving the internal register bus.
// Optional BUSY watchdog: define RGGEN_HOST_IF_APB_WATCHDOG_EN.
module rggen_host_if_apb
   import rggen_rtl_pkg::*;
#(
   parameter int ADDRESS_WIDTH  = 16,
   parameter int DATA_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 256
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      i_psel,
   input  logic                      i_penable,
   input  logic [ADDRESS_WIDTH-1:0]  i_paddr,
   input  logic                      i_pwrite,
   input  logic [DATA_WIDTH-1:0]     i_pwdata,
   input  logic [DATA_WIDTH/8-1:0]   i_pstrb,
   output logic                      o_pready,
   output logic [DATA_WIDTH-1:0]     o_prdata,
   output logic                      o_pslverr,
   output logic                      o_request,
   output logic [ADDRESS_WIDTH-1:0]  o_address,
   output logic                      o_write,
   output logic [DATA_WIDTH-1:0]     o_write_data,
   output logic [DATA_WIDTH/8-1:0]   o_strobe,
   input  logic                      i_select,
   input  logic                      i_ready,
   input  rggen_status               i_status,
   input  logic [DATA_WIDTH-1:0]     i_read_data
);

   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] BUSY    = 2'd1;
   localparam logic [1:0] RESPOND = 2'd2;

   logic [1:0]               r_state;
   logic [1:0]               w_next;
   logic                     w_setup;
   logic                     w_busy;
   logic                     w_done;
   logic                     w_timeout;
   logic                     r_request;
   logic                     r_pready;
   logic                     r_pslverr;
   logic [DATA_WIDTH-1:0]    r_prdata;
   logic [ADDRESS_WIDTH-1:0] r_address;
   logic                     r_write;
   logic [DATA_WIDTH-1:0]    r_write_data;
   logic [DATA_WIDTH/8-1:0]  r_strobe;

   assign w_setup = (r_state == IDLE) && i_psel && !i_penable;
   assign w_busy  = (r_state == BUSY);
   assign w_done  = w_busy && (i_ready || !i_select || w_timeout);

`ifdef RGGEN_HOST_IF_APB_WATCHDOG_EN
   rggen_host_if_watchdog #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_watchdog (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_start   (w_setup),
      .i_busy    (w_busy),
      .o_timeout (w_timeout)
   );
`else
   logic w_unused_timeout;
   assign w_unused_timeout = (TIMEOUT_CYCLES == 0);
   assign w_timeout        = 1'b0;
`endif

   // Next-state selection for the single-outstanding transfer FSM.
   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (w_setup) w_next = BUSY;
         BUSY:    if (w_done)  w_next = RESPOND;
         RESPOND: w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   // State plus registered handshake outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= IDLE;
         r_request <= 1'b0;
         r_pready  <= 1'b0;
      end else begin
         r_state   <= w_next;
         r_request <= (w_next == BUSY);
         r_pready  <= (w_next == RESPOND);
      end
   end

   // Capture the APB request at setup; held for the whole transfer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_address    <= '0;
         r_write      <= 1'b0;
         r_write_data <= '0;
         r_strobe     <= '0;
      end else if (w_setup) begin
         r_address    <= i_paddr;
         r_write      <= i_pwrite;
         r_write_data <= i_pwdata;
         r_strobe     <= i_pwrite ? i_pstrb : '1;
      end
   end

   // Response data is nonzero only during the RESPOND cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_prdata  <= '0;
         r_pslverr <= 1'b0;
      end else if (w_done && i_ready) begin
         r_prdata  <= r_write ? '0 : i_read_data;
         r_pslverr <= is_error(i_status);
      end else if (w_done) begin
         r_prdata  <= '0;
         r_pslverr <= 1'b1;
      end else begin
         r_prdata  <= '0;
         r_pslverr <= 1'b0;
      end
   end

   assign o_pready     = r_pready;
   assign o_prdata     = r_prdata;
   assign o_pslverr    = r_pslverr;
   assign o_request    = r_request;
   assign o_address    = r_address;
   assign o_write      = r_write;
   assign o_write_data = r_write_data;
   assign o_strobe     = r_strobe;

endmodule
